// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: register map addresses, CTRL register bit
// positions and the encoding of the divisor-change FSM used by baud_cfg_ctrl.
// ---------------------------------------------------------------------------
package uart_pkg;

   // Register map (2-bit address space)
   localparam logic [1:0] ADDR_DLL    = 2'd0;
   localparam logic [1:0] ADDR_DLH    = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // CTRL register bit positions (write-only strobes, never stored)
   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_FORCE_BIT  = 1;
   localparam int CTRL_CLR_BIT    = 2;

   // Divisor-change sequencer states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_IDLE = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RELEASE   = 2'd3
   } cfg_state_e;

endpackage : uart_pkg

// File: rtl/baud_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// baud_cfg_ctrl
// Register front-end for the UART baud generator. Software writes a new
// divisor into shadow DLL/DLH registers and commits it through CTRL. The
// commit waits for the transmitter and receiver to be idle (unless forced),
// then loads the shadow into div while holding the baud generator in reset
// for HOLD_CYC cycles, and finally pulses cfg_done.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   wr_en    : register write strobe
//   rd_en    : register read strobe
//   addr     : register select (DLL, DLH, CTRL, STATUS)
//   wdata    : write data
//   rdata    : registered read data, holds when rd_en is low
//   tx_busy  : transmitter mid-frame
//   rx_busy  : receiver mid-frame
//   div      : active divisor {DLH,DLL} to the baud generator
//   bg_rst   : active-high reset to the baud generator
//   cfg_done : one-cycle pulse when a new divisor takes effect
//   cfg_err  : sticky flag, set when a zero divisor commit is rejected
// ---------------------------------------------------------------------------
module baud_cfg_ctrl
   import uart_pkg::*;
#(
   parameter logic [15:0] DIV_RST  = 16'h0006,
   parameter int          HOLD_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   input  logic        tx_busy,
   input  logic        rx_busy,
   output logic [15:0] div,
   output logic        bg_rst,
   output logic        cfg_done,
   output logic        cfg_err
);

   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

   cfg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       dll_q, dll_d;
   logic [7:0]       dlh_q, dlh_d;
   logic [15:0]      div_q, div_d;
   logic             bg_rst_q, bg_rst_d;
   logic             cfg_done_q, cfg_done_d;
   logic             cfg_err_q, cfg_err_d;
   logic [7:0]       rdata_q, rdata_d;

   logic             wr_ctrl;
   logic             commit;
   logic             frc;
   logic             clr_err;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dll_d      = dll_q;
      dlh_d      = dlh_q;
      div_d      = div_q;
      cfg_err_d  = cfg_err_q;
      rdata_d    = rdata_q;

      wr_ctrl = wr_en && (addr == ADDR_CTRL);
      commit  = wr_ctrl && wdata[CTRL_COMMIT_BIT];
      frc     = wr_ctrl && wdata[CTRL_FORCE_BIT];
      clr_err = wr_ctrl && wdata[CTRL_CLR_BIT];

      // Shadow writes are accepted in every state; div only moves on HOLD entry.
      if (wr_en && (addr == ADDR_DLL)) dll_d = wdata;
      if (wr_en && (addr == ADDR_DLH)) dlh_d = wdata;

      // Clear is applied before the commit is evaluated, so a combined
      // clear+commit of a zero divisor leaves the flag set.
      if (clr_err) cfg_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (commit) begin
               if ({dlh_q, dll_q} == 16'h0000) cfg_err_d = 1'b1;
               else if (frc)                   state_d   = ST_HOLD;
               else                            state_d   = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if ((commit && frc) || (!tx_busy && !rx_busy)) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cnt_q == CNT_LAST) state_d = ST_RELEASE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Divisor is captured from the shadow as it stands before this edge.
      if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
         div_d = {dlh_q, dll_q};
         cnt_d = '0;
      end

      bg_rst_d   = (state_d == ST_HOLD);
      cfg_done_d = (state_d == ST_RELEASE);

      if (rd_en) begin
         unique case (addr)
            ADDR_DLL:    rdata_d = dll_q;
            ADDR_DLH:    rdata_d = dlh_q;
            ADDR_CTRL:   rdata_d = 8'h00;
            ADDR_STATUS: rdata_d = {4'b0000, (state_q != ST_IDLE), cfg_err_q,
                                    tx_busy, rx_busy};
            default:     rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         dll_q      <= DIV_RST[7:0];
         dlh_q      <= DIV_RST[15:8];
         div_q      <= DIV_RST;
         bg_rst_q   <= 1'b1;
         cfg_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         rdata_q    <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dll_q      <= dll_d;
         dlh_q      <= dlh_d;
         div_q      <= div_d;
         bg_rst_q   <= bg_rst_d;
         cfg_done_q <= cfg_done_d;
         cfg_err_q  <= cfg_err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign div      = div_q;
   assign bg_rst   = bg_rst_q;
   assign cfg_done = cfg_done_q;
   assign cfg_err  = cfg_err_q;
   assign rdata    = rdata_q;

endmodule : baud_cfg_ctrl

// File: doc/baud_cfg_ctrl.md
BAUD_CFG_CTRL -- requirements
Module: baud_cfg_ctrl

Interface
REQ-001 Parameter DIV_RST, default 16'h0006: divisor driven on div after reset.
REQ-002 Parameter HOLD_CYC, default 2: cycles bg_rst is held asserted during a divisor change.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port wr_en  input  1  register write strobe, one cycle per write.
REQ-006 Port rd_en  input  1  register read strobe.
REQ-007 Port addr  input  2  register select: 0 DLL, 1 DLH, 2 CTRL, 3 STATUS.
REQ-008 Port wdata  input  8  write data.
REQ-009 Port rdata  output  8  read data, registered.
REQ-010 Port tx_busy  input  1  transmitter mid-frame.
REQ-011 Port rx_busy  input  1  receiver mid-frame.
REQ-012 Port div  output  16  active divisor to baud_gen, {DLH,DLL}.
REQ-013 Port bg_rst  output  1  active-high reset to baud_gen.
REQ-014 Port cfg_done  output  1  one-cycle pulse when a new divisor takes effect.
REQ-015 Port cfg_err  output  1  sticky flag: commit of zero divisor rejected.

Function
REQ-016 Writes to addr 0/1 SHALL update shadow DLL/DLH only; div SHALL NOT change on shadow writes.
REQ-017 Write to CTRL: bit0 = commit, bit1 = force (ignore busy), bit2 = clear cfg_err; other bits ignored, not stored.
REQ-018 rdata SHALL update one cycle after rd_en: addr 0/1 shadow bytes, addr 2 8'h00, addr 3 {4'b0, state!=IDLE, cfg_err, tx_busy, rx_busy}; rdata holds its value when rd_en is low.
REQ-019 FSM states: IDLE, WAIT_IDLE, HOLD, RELEASE.
REQ-020 IDLE: a commit with shadow == 0 SHALL set cfg_err and remain IDLE; a nonzero commit SHALL go to WAIT_IDLE, or to HOLD directly if force=1.
REQ-021 WAIT_IDLE -> HOLD on the first cycle with tx_busy=0 and rx_busy=0; a forced commit while in WAIT_IDLE SHALL go to HOLD next cycle.
REQ-022 On entry to HOLD: latch the shadow into div and assert bg_rst; remain for HOLD_CYC cycles (counter).
REQ-023 RELEASE: deassert bg_rst, pulse cfg_done for exactly one cycle, return to IDLE.
REQ-024 Commit latency with idle UART and force=0: div changes 2 cycles after the write; cfg_done asserts HOLD_CYC+2 cycles after the write.
REQ-025 Shadow writes during WAIT_IDLE/HOLD SHALL be accepted; div SHALL take the shadow value present at HOLD entry.
REQ-026 Commits received outside IDLE (other than force in WAIT_IDLE) SHALL be ignored.
REQ-027 Simultaneous commit and clear-error in one write: clear first, then evaluate the commit.

Reset
REQ-028 On rst low: shadow = DLL/DLH of DIV_RST, div = DIV_RST, bg_rst = 1, cfg_done = 0, cfg_err = 0, rdata = 0, state IDLE, counter 0.
REQ-029 bg_rst SHALL deassert on the first clock edge after rst is released.
REQ-030 Reset mid-operation aborts any pending commit; no cfg_done pulse.

Structure
REQ-031 Register addresses, CTRL bit positions and FSM state encodings SHALL live in shared package uart_pkg.
REQ-032 No sub-module; baud_gen is instantiated by the parent alongside this block, not inside it.

Verification
REQ-033 Reset, then read DLL/DLH -> rdata 8'h06 then 8'h00; div=16'h0006, bg_rst=0 after the first edge.
REQ-034 Write DLL=8'h1A, DLH=8'h00, CTRL=8'h01 with UART idle -> div=16'h001A 2 cycles later; bg_rst high for 2 cycles; one cfg_done pulse.
REQ-035 tx_busy=1, commit 16'h0034 -> div stays 16'h0006 until tx_busy falls; update follows the next cycle.
REQ-036 Shadow 16'h0000, commit -> cfg_err=1, div unchanged; write CTRL=8'h04 -> cfg_err=0.
REQ-037 rx_busy=1, commit, then CTRL=8'h03 -> HOLD next cycle despite busy; div updated.
REQ-038 rst low during HOLD -> div=16'h0006, bg_rst=1, cfg_done never pulses.
